// File: rtl/systolic_fir_array.sv
// -----------------------------------------------------------------------------
// systolic_fir_array
//
// Transposed-form FIR filter built from PE_NUM processing elements. PE i holds
// weight w[i] and partial-sum register r[i]; each accepted sample x produces
// one output y = w[0]*x + r[1] one cycle later, while the partial sums shift
// one PE towards the output. Weights are loaded serially over a valid/ready
// handshake (first beat lands in w[0]). A stream of samples ends with x_last.
// The array then injects PE_NUM-1 zero samples to drain the partial sums. The
// final drained output carries y_last.
//
// Optional build macro:
//   SYSTOLIC_SATURATE_EN - every adder saturates to the signed ACC_W range and
//                          raises the sticky ovf flag. Without it, sums wrap
//                          modulo 2^ACC_W and ovf is tied to 0.
//
// Parameters:
//   PE_NUM  number of taps / PEs (>= 1)
//   DATA_W  signed sample and weight width
//   ACC_W   signed accumulator / output width (>= 2*DATA_W)
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   w_valid/w_ready/w_data   weight-load handshake (IDLE and LOAD only)
//   x_valid/x_ready/x_data   sample stream, x_last marks the final sample
//   x_last
//   y_valid/y_ready/y_data   result stream, y_last marks the final result
//   y_last
//   busy                     FSM is not in IDLE
//   ovf                      sticky saturation flag (saturating build only)
// -----------------------------------------------------------------------------
module systolic_fir_array #(
    parameter int PE_NUM = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic                     x_last,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic signed [ACC_W-1:0]  y_data,
    output logic                     y_last,
    output logic                     busy,
    output logic                     ovf
);

    localparam int PW         = 2 * DATA_W;
    localparam int CW         = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int LOAD_LAST  = PE_NUM - 1;
    localparam int FLUSH_LAST = (PE_NUM > 1) ? PE_NUM - 2 : 0;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [DATA_W-1:0] w [PE_NUM];
    logic                     loaded;
    logic [CW-1:0]            cnt;       // weight beats in LOAD, zero samples in FLUSH

    logic                     slot_free;
    logic                     x_fire;
    logic                     step;
    logic                     load_start;
    logic                     load_beat;
    logic                     load_done;
    logic                     run_entry;
    logic                     flush_done;
    logic                     last_nxt;
    logic signed [DATA_W-1:0] sample;
    logic signed [ACC_W-1:0]  prod [PE_NUM];
    logic signed [ACC_W-1:0]  y_nxt;

    logic                     vld_p1;
    logic                     last_p1;
    logic signed [ACC_W-1:0]  y_data_p1;

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return ACC_W'(p);
    endfunction

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    function automatic logic acc_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    logic step_ovf;
`else
    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        return a + b;
    endfunction
`endif

    // Control decode shared by the FSM and the datapath.
    always_comb begin
        slot_free  = !vld_p1 || y_ready;
        x_fire     = (state == RUN) && slot_free && x_valid;
        step       = x_fire || ((state == FLUSH) && slot_free);
        load_start = (state == IDLE) && w_valid;
        load_beat  = (state == LOAD) && w_valid;
        load_done  = (load_beat && (cnt == CW'(LOAD_LAST))) || (load_start && (PE_NUM == 1));
        run_entry  = (state == IDLE) && !w_valid && x_valid && loaded;
        flush_done = (state == FLUSH) && slot_free && (cnt == CW'(FLUSH_LAST));
        last_nxt   = flush_done || ((PE_NUM == 1) && x_fire && x_last);
        sample     = (state == FLUSH) ? '0 : x_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start)     state_nxt = (PE_NUM == 1) ? IDLE : LOAD;
                else if (run_entry) state_nxt = RUN;
            end
            LOAD:  if (load_done) state_nxt = IDLE;
            RUN:   if (x_fire && x_last) state_nxt = (PE_NUM == 1) ? IDLE : FLUSH;
            FLUSH: if (flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ready = reset && ((state == IDLE) || (state == LOAD));
        x_ready = (state == RUN) && slot_free;
        busy    = (state != IDLE);
        y_valid = vld_p1;
        y_last  = last_p1;
        y_data  = y_data_p1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            loaded <= 1'b0;
        end else begin
            if (load_start)                cnt <= CW'(1);
            else if (load_beat)            cnt <= cnt + CW'(1);
            else if (x_fire && x_last)     cnt <= '0;
            else if ((state == FLUSH) && slot_free) cnt <= cnt + CW'(1);

            // A partial reload invalidates the previous weight set.
            if (load_done)       loaded <= 1'b1;
            else if (load_start) loaded <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PE_NUM; i++) w[i] <= '0;
        end else if (load_start || load_beat) begin
            for (int i = 0; i < PE_NUM - 1; i++) w[i] <= w[i+1];
            w[PE_NUM-1] <= w_data;
        end
    end

    // ---- stage p0: per-PE products and partial-sum chain ----
    always_comb begin
        for (int i = 0; i < PE_NUM; i++) prod[i] = mul_ext(w[i], sample);
    end

    generate
        if (PE_NUM > 1) begin : g_chain
            logic signed [ACC_W-1:0] psum_p0  [1:PE_NUM-1];
            logic signed [ACC_W-1:0] psum_nxt [1:PE_NUM-1];

            always_comb begin
                psum_nxt[PE_NUM-1] = prod[PE_NUM-1];
                for (int i = 1; i < PE_NUM - 1; i++) psum_nxt[i] = acc_add(prod[i], psum_p0[i+1]);
            end

            assign y_nxt = acc_add(prod[0], psum_p0[1]);

`ifdef SYSTOLIC_SATURATE_EN
            always_comb begin
                step_ovf = acc_ovf(prod[0], psum_p0[1]);
                for (int i = 1; i < PE_NUM - 1; i++)
                    step_ovf = step_ovf | acc_ovf(prod[i], psum_p0[i+1]);
            end
`endif

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 1; i < PE_NUM; i++) psum_p0[i] <= '0;
                end else if (run_entry) begin
                    for (int i = 1; i < PE_NUM; i++) psum_p0[i] <= '0;
                end else if (step) begin
                    psum_p0 <= psum_nxt;
                end
            end
        end else begin : g_single
            assign y_nxt = prod[0];
`ifdef SYSTOLIC_SATURATE_EN
            assign step_ovf = 1'b0;
`endif
        end
    endgenerate

    // ---- stage p1: output register, held while the consumer stalls ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            y_data_p1 <= '0;
        end else if (step) begin
            vld_p1    <= 1'b1;
            last_p1   <= last_nxt;
            y_data_p1 <= y_nxt;
        end else if (y_ready) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end
    end

`ifdef SYSTOLIC_SATURATE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                ovf <= 1'b0;
        else if (load_start)       ovf <= 1'b0;
        else if (step && step_ovf) ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_fir_array.sv
module tb_systolic_fir_array;

    localparam int PE  = 4;
    localparam int DW  = 16;
    localparam int AW  = 40;
    localparam int AW2 = 32;

    logic                 clk;
    logic                 reset;
    logic                 w_valid, w_ready;
    logic signed [DW-1:0] w_data;
    logic                 x_valid, x_ready, x_last;
    logic signed [DW-1:0] x_data;
    logic                 y_valid, y_ready, y_last;
    logic signed [AW-1:0] y_data;
    logic                 busy, ovf;

    logic                  w_valid2, w_ready2;
    logic signed [DW-1:0]  w_data2;
    logic                  x_valid2, x_ready2, x_last2;
    logic signed [DW-1:0]  x_data2;
    logic                  y_valid2, y_ready2, y_last2;
    logic signed [AW2-1:0] y_data2;
    logic                  busy2, ovf2;

    typedef struct {
        logic [AW-1:0] y;
        logic          last;
    } exp_t;

    exp_t                 exp_q[$];
    logic [AW2-1:0]       y2_q[$];
    logic signed [DW-1:0] tb_w [PE];
    logic signed [DW-1:0] stream_q[$];
    int                   errors = 0;
    int                   checks = 0;
    bit                   chk_en = 1'b1;
    bit                   rdy_rand = 1'b0;
    bit                   gap_en = 1'b0;
    logic                 rdy_force = 1'b1;

    systolic_fir_array #(.PE_NUM(PE), .DATA_W(DW), .ACC_W(AW)) u_dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .busy(busy), .ovf(ovf)
    );

    systolic_fir_array #(.PE_NUM(PE), .DATA_W(DW), .ACC_W(AW2)) u_dut32 (
        .clk(clk), .reset(reset),
        .w_valid(w_valid2), .w_ready(w_ready2), .w_data(w_data2),
        .x_valid(x_valid2), .x_ready(x_ready2), .x_data(x_data2), .x_last(x_last2),
        .y_valid(y_valid2), .y_ready(y_ready2), .y_data(y_data2), .y_last(y_last2),
        .busy(busy2), .ovf(ovf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Consumer ready: either random backpressure or a forced level.
    initial begin
        y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            y_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Output scoreboard: every cycle y_valid is high the data must equal the
    // head of the expected queue; the head retires on a transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && y_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL y_extra actual y_data=%0h y_last=%0b required no output", y_data, y_last);
                end else begin
                    if (y_data !== exp_q[0].y || y_last !== exp_q[0].last) begin
                        errors++;
                        $display("FAIL y_stream actual y_data=%0h y_last=%0b required y_data=%0h y_last=%0b",
                                 y_data, y_last, exp_q[0].y, exp_q[0].last);
                    end
                    if (y_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Collector for the 32-bit instance (its y_ready is held high).
    initial begin
        forever begin
            @(negedge clk);
            if (y_valid2 && y_ready2) y2_q.push_back(y_data2);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] y, input logic l);
        exp_q.push_back('{y: y, last: l});
    endtask

    // Reference: direct convolution y[n] = sum_k w[k]*x[n-k] over the stream
    // extended by PE-1 zeros; the last output carries the last flag.
    task automatic push_model();
        int     n_in;
        int     n_out;
        longint acc;
        n_in  = stream_q.size();
        n_out = n_in + PE - 1;
        for (int n = 0; n < n_out; n++) begin
            acc = 0;
            for (int k = 0; k < PE; k++)
                if (n - k >= 0 && n - k < n_in)
                    acc += longint'(tb_w[k]) * longint'(stream_q[n-k]);
            exp_q.push_back('{y: acc[AW-1:0], last: 1'(n == n_out - 1)});
        end
    endtask

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic load_w();
        int n;
        for (int k = 0; k < PE; k++) begin
            w_valid = 1'b1;
            w_data  = tb_w[k];
            n = 0;
            @(negedge clk);
            while (!w_ready && n < 100) begin @(negedge clk); n++; end
            if (!w_ready) begin
                checks++; errors++;
                $display("FAIL w_accept actual timeout required w_ready=1");
            end
            @(posedge clk); #1;
            w_valid = 1'b0;
            if (gap_en && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_beat(input logic signed [DW-1:0] d, input logic l);
        int n;
        x_valid = 1'b1;
        x_data  = d;
        x_last  = l;
        n = 0;
        @(negedge clk);
        while (!x_ready && n < 300) begin @(negedge clk); n++; end
        if (!x_ready) begin
            checks++; errors++;
            $display("FAIL x_accept actual timeout required x_ready=1");
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic run_stream(input bit use_model);
        if (use_model) push_model();
        for (int i = 0; i < stream_q.size(); i++) begin
            send_beat(stream_q[i], 1'(i == stream_q.size() - 1));
            if (gap_en && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || y_valid || exp_q.size() != 0) && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (busy || y_valid || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_idle actual busy=%0b pending=%0d required busy=0 pending=0", name, busy, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        w_valid = 0; w_data = 0; x_valid = 0; x_data = 0; x_last = 0;
        w_valid2 = 0; w_data2 = 0; x_valid2 = 0; x_data2 = 0; x_last2 = 0; y_ready2 = 1'b1;
        #2 reset = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_y_last", y_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_w_ready", w_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_w_ready", w_ready, 1);
        @(posedge clk); #1;

        // No weights loaded yet: samples must not be taken
        x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("noload_x_ready", x_ready, 0);
            chk("noload_busy", busy, 0);
        end
        @(posedge clk); #1;
        x_valid = 1'b0;

        // 32-bit accumulator overflow case
        w_valid2 = 1'b1; w_data2 = -16'sd32768;
        repeat (PE) begin @(posedge clk); #1; end
        w_valid2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x_valid2 = 1'b1; x_data2 = -16'sd32768; x_last2 = 1'(i == 1);
            n = 0;
            @(negedge clk);
            while (!x_ready2 && n < 50) begin @(negedge clk); n++; end
            if (!x_ready2) begin
                checks++; errors++;
                $display("FAIL x2_accept actual timeout required x_ready=1");
            end
            @(posedge clk); #1;
        end
        x_valid2 = 1'b0; x_last2 = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        chk("acc32_count", 64'(y2_q.size()), 5);
        if (y2_q.size() >= 2) begin
            chk("acc32_y0", y2_q[0], 32'h4000_0000);
`ifdef SYSTOLIC_SATURATE_EN
            chk("acc32_y1_sat", y2_q[1], 32'h7FFF_FFFF);
            chk("acc32_ovf", ovf2, 1);
`else
            chk("acc32_y1_wrap", y2_q[1], 32'h8000_0000);
            chk("acc32_ovf", ovf2, 0);
`endif
        end

        // Impulse through w = 1,2,3,4
        tb_w[0] = 16'sd1; tb_w[1] = 16'sd2; tb_w[2] = 16'sd3; tb_w[3] = 16'sd4;
        load_w();
        for (int r = 0; r < 2; r++) begin
            push_exp(40'd1, 1'b0); push_exp(40'd2, 1'b0); push_exp(40'd3, 1'b0); push_exp(40'd4, 1'b0);
            push_exp(40'd0, 1'b0); push_exp(40'd0, 1'b0); push_exp(40'd0, 1'b1);
            stream_q = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
            run_stream(1'b0);
            wait_idle(r == 0 ? "impulse" : "impulse_reuse");
        end

        // Output stall while streaming 5,6
        rdy_force = 1'b0;
        @(posedge clk); #1;
        push_exp(40'd5, 1'b0); push_exp(40'd16, 1'b0); push_exp(40'd27, 1'b0);
        push_exp(40'd38, 1'b0); push_exp(40'd24, 1'b1);
        send_beat(16'sd5, 1'b0);
        x_valid = 1'b1; x_data = 16'sd6; x_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_x_ready", x_ready, 0);
            chk("stall_y_valid", y_valid, 1);
        end
        rdy_force = 1'b1;
        send_beat(16'sd6, 1'b1);
        wait_idle("stall");

        // Most-negative sample against w = -1
        for (int k = 0; k < PE; k++) tb_w[k] = -16'sd1;
        load_w();
        push_exp(40'd32768, 1'b0); push_exp(40'd32768, 1'b0);
        push_exp(40'd32768, 1'b0); push_exp(40'd32768, 1'b1);
        stream_q = '{-16'sd32768};
        run_stream(1'b0);
        wait_idle("minval");

        // Randomized streams with backpressure and input gaps
        rdy_rand = 1'b1;
        gap_en   = 1'b1;
        for (int t = 0; t < 24; t++) begin
            if (t % 3 == 0) begin
                for (int k = 0; k < PE; k++)
                    tb_w[k] = ($urandom_range(0, 7) == 0) ? -16'sd32768 : DW'($urandom);
                load_w();
            end
            stream_q.delete();
            repeat ($urandom_range(1, 9))
                stream_q.push_back(($urandom_range(0, 7) == 0) ? -16'sd32768 : DW'($urandom));
            run_stream(1'b1);
            wait_idle("random");
        end
        rdy_rand = 1'b0;
        gap_en   = 1'b0;
        rdy_force = 1'b1;
        @(posedge clk); #1;
        chk("ovf_40bit", ovf, 0);

        // Reset asserted while draining
        rdy_force = 1'b0;
        @(posedge clk); #1;
        stream_q = '{16'sd1};
        push_model();
        send_beat(16'sd1, 1'b1);
        @(negedge clk);
        chk("flush_busy", busy, 1);
        chk("flush_y_valid", y_valid, 1);
        @(posedge clk); #1;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("arst_y_valid", y_valid, 0);
        chk("arst_y_data", y_data, 0);
        chk("arst_y_last", y_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_x_ready", x_ready, 0);
        chk("arst_w_ready", w_ready, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        rdy_force = 1'b1;
        x_valid = 1'b1;
        x_data  = 16'sd7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_x_ready", x_ready, 0);
            chk("post_rst_y_valid", y_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
        chk_en  = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #900000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

endmodule
